alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the 8-bit registered ALU interface.
- Accepts one operation command at a time over a valid/ready handshake, then drives the operands and 3-bit opcode to the ALU.
- Waits the ALU's fixed pipeline latency, captures the 16-bit result, and returns it with the command's tag over a second valid/ready handshake.
- Sits between the control sequencer and the ALU, so upstream logic never needs to track ALU timing.

Parameters:
- LATENCY, 1, number of ALU register stages between opcode/operand inputs and OUT (range 1..7).
- TAG_W, 4, width of the command/response tag.

Ports:
- clk  in  1  processor clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer can accept a command.
- cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 XNOR.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_tag  in  TAG_W  caller tag, returned unchanged.
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_opcode  out  3  to ALU opcode.
- alu_out  in  16  ALU OUT.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  16  captured ALU result.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_err  out  1  set for DIV with cmd_b == 0.
- op_count  out  16  completed-response counter.

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high and takes priority over every other event.
- Reset values: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_tag=0; rsp_err=0; alu_a=0; alu_b=0; alu_opcode=000; op_count=0. Internal latency counter = 0.
- FSM states: IDLE, WAIT, RESP.
- cmd_ready = (state==IDLE). It depends on state only, never combinationally on cmd_valid or rsp_ready.
- IDLE: on edge T0 with cmd_valid & cmd_ready:
  - register cmd_a → alu_a, cmd_b → alu_b, cmd_op → alu_opcode;
  - latch cmd_tag;
  - latch err = (cmd_op==011 && cmd_b==0);
  - load counter with LATENCY; go to WAIT.
  - No accept → stay in IDLE, alu_* hold their values.
- WAIT:
  - alu_* held stable.
  - Counter decrements each edge.
  - On the edge where the counter is 0 (edge T0+LATENCY+1):
    - alu_out → rsp_data, tag → rsp_tag, err → rsp_err;
    - rsp_valid=1; go to RESP.
  - Accept-to-rsp_valid = LATENCY+1 cycles (2 for the default).
- RESP:
  - rsp_valid=1; rsp_data, rsp_tag, rsp_err held stable until handshake.
  - On edge with rsp_ready=1: rsp_valid=0, op_count increments, go to IDLE.
  - rsp_ready low holds indefinitely; no new command is accepted while in RESP.
- Throughput: one operation per LATENCY+3 cycles when rsp_ready is tied high.
- rsp_err is informational only: rsp_data always carries the unmodified alu_out.
- op_count wraps 16'hFFFF → 16'h0000.
- alu_* outputs keep their last issued values after capture, until the next accept.
- rsp_data/rsp_tag/rsp_err keep their last values after the response handshake. rsp_valid is the only qualifier.
- Reset mid-operation (WAIT or RESP): outstanding result discarded, no response issued, all outputs return to reset values on that edge, op_count cleared. alu_out is ignored during and after reset until a new command's capture edge.
- cmd_valid asserted during reset: not accepted. First possible accept is the first edge after rst deasserts.
- No combinational path from alu_out to any output; rsp_data is registered.

Test Plan:
- Bench instantiates a behavioural registered ALU model with latency LATENCY.
- Default LATENCY: ADD A=8'hFF, B=8'h01, tag=3, rsp_ready=1 → rsp_valid rises 2 cycles after accept; rsp_data=16'h0100 (ALU packs {cout,sum}); rsp_tag=3; rsp_err=0; op_count=1 after handshake.
- MUL A=8'h0F, B=8'h10 with rsp_ready held 0 for 5 cycles → rsp_data=16'h00F0 stable through all 5 cycles; cmd_ready=0 throughout; a cmd_valid pulse during RESP is not accepted; single handshake when rsp_ready=1.
- DIV A=8'h20, B=8'h00 → rsp_err=1, rsp_data equals the model's output. Then DIV A=8'h20, B=8'h04 → rsp_err=0.
- Assert rst in the WAIT cycle after accepting XOR A=8'hAA, B=8'h55 → next edge: rsp_valid=0, cmd_ready=1, alu_opcode=000, op_count=0; no response ever appears for that command.
- LATENCY=3 build: back-to-back SUB/AND/OR/XNOR with random operands and rsp_ready always 1 → each rsp_valid exactly 4 cycles after its accept; one op per 6 cycles; results match the model.
- Preload by running 65536 responses (or force op_count=16'hFFFF) → next handshake gives op_count=16'h0000.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Initiator for the 8-bit registered ALU: accepts one command, waits out the
// ALU pipeline latency, then returns the captured result with its tag.
`timescale 1ns/1ps
module alu_cmd_issuer #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [15:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      op_count
);

  localparam logic [2:0] LAT_INIT = 3'(LATENCY);
  localparam logic [2:0] OP_DIV   = 3'b011;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [2:0]       cnt;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic             accept, capture, done;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (cmd_valid) begin
        accept     = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (cnt == '0) begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: if (rsp_ready) begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter is loaded with LATENCY and captures one edge after reaching zero,
  // giving the ALU output a full cycle to settle after its last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cnt        <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_opcode <= cmd_op;
        cnt        <= LAT_INIT;
        tag_q      <= cmd_tag;
        err_q      <= (cmd_op == OP_DIV) && (cmd_b == '0);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 3'd1;
      end
      if (capture) begin
        rsp_data <= alu_out;
        rsp_tag  <= tag_q;
        rsp_err  <= err_q;
      end
      if (done) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with behavioural registered ALU models
// at latency 1 (dut1) and latency 3 (dut3).
`timescale 1ns/1ps
module tb_alu_cmd_issuer;

  logic clk, rst;
  int total, bad;

  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  cmd_op, alu_opcode;
  logic [7:0]  cmd_a, cmd_b, alu_a, alu_b;
  logic [3:0]  cmd_tag, rsp_tag;
  logic [15:0] alu_out, rsp_data, op_count;

  logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_err3;
  logic [2:0]  cmd_op3, alu_opcode3;
  logic [7:0]  cmd_a3, cmd_b3, alu_a3, alu_b3;
  logic [3:0]  cmd_tag3, rsp_tag3;
  logic [15:0] alu_out3, rsp_data3, op_count3;

  alu_cmd_issuer #(.LATENCY(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .op_count(op_count));

  alu_cmd_issuer #(.LATENCY(3), .TAG_W(4)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_tag(cmd_tag3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3), .alu_out(alu_out3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .rsp_tag(rsp_tag3), .rsp_err(rsp_err3), .op_count(op_count3));

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return 16'(a) + 16'(b);
      3'd1: return 16'(a) - 16'(b);
      3'd2: return 16'(a) * 16'(b);
      3'd3: return (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
      3'd4: return {8'h00, a & b};
      3'd5: return {8'h00, a | b};
      3'd6: return {8'h00, a ^ b};
      default: return {8'h00, ~(a ^ b)};
    endcase
  endfunction

  logic [15:0] p1;
  logic [15:0] p3 [3];
  always @(posedge clk) p1 <= alu_f(alu_opcode, alu_a, alu_b);
  always @(posedge clk) begin
    p3[0] <= alu_f(alu_opcode3, alu_a3, alu_b3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign alu_out  = p1;
  assign alu_out3 = p3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one command into dut1; lat = edges from accept until rsp_valid (20 = timeout).
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag, output int lat);
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    lat = 0;
    while (!cmd_ready && lat < 20) begin @(negedge clk); lat++; end
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 8'h77; cmd_b = 8'h11; cmd_tag = 4'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset cmd_ready got=%h want=1", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset rsp_valid got=%h want=0", rsp_valid); end
    total++; if (rsp_data !== 16'h0000) begin bad++; $display("FAIL reset rsp_data got=%h want=0000", rsp_data); end
    total++; if (rsp_tag !== 4'h0) begin bad++; $display("FAIL reset rsp_tag got=%h want=0", rsp_tag); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset rsp_err got=%h want=0", rsp_err); end
    total++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin bad++; $display("FAIL reset alu_ab got=%h/%h want=00/00", alu_a, alu_b); end
    total++; if (alu_opcode !== 3'b000) begin bad++; $display("FAIL reset alu_opcode got=%b want=000", alu_opcode); end
    total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL reset op_count got=%h want=0000", op_count); end
    total++; if (rsp_valid3 !== 1'b0 || cmd_ready3 !== 1'b1) begin bad++; $display("FAIL reset dut3 got=%b%b want=01", rsp_valid3, cmd_ready3); end
    cmd_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++; if (alu_a !== 8'h00 || cmd_ready !== 1'b1) begin bad++; $display("FAIL post_reset got=%h/%h want=00/1", alu_a, cmd_ready); end
  endtask

  task automatic test_add();
    int lat;
    rsp_ready = 1'b1;
    issue(3'd0, 8'hFF, 8'h01, 4'h3, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL add latency got=%0d want=2", lat); end
    total++; if (rsp_data !== 16'h0100) begin bad++; $display("FAIL add rsp_data got=%h want=0100", rsp_data); end
    total++; if (rsp_tag !== 4'h3) begin bad++; $display("FAIL add rsp_tag got=%h want=3", rsp_tag); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL add rsp_err got=%h want=0", rsp_err); end
    total++; if (alu_a !== 8'hFF || alu_b !== 8'h01) begin bad++; $display("FAIL add alu_ab got=%h/%h want=ff/01", alu_a, alu_b); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add rsp_valid_after got=%h want=0", rsp_valid); end
    total++; if (op_count !== 16'd1) begin bad++; $display("FAIL add op_count got=%h want=0001", op_count); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL add cmd_ready_after got=%h want=1", cmd_ready); end
    total++; if (rsp_data !== 16'h0100) begin bad++; $display("FAIL add rsp_data_held got=%h want=0100", rsp_data); end
  endtask

  task automatic test_resp_hold();
    int lat;
    rsp_ready = 1'b0;
    issue(3'd2, 8'h0F, 8'h10, 4'h5, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL mul latency got=%0d want=2", lat); end
    for (int k = 0; k < 5; k++) begin
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold rsp_valid c%0d got=%h want=1", k, rsp_valid); end
      total++; if (rsp_data !== 16'h00F0) begin bad++; $display("FAIL hold rsp_data c%0d got=%h want=00f0", k, rsp_data); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL hold cmd_ready c%0d got=%h want=0", k, cmd_ready); end
      if (k == 1) begin cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'h01; cmd_b = 8'h01; cmd_tag = 4'h7; end
      if (k == 3) cmd_valid = 1'b0;
      if (k == 4) rsp_ready = 1'b1;
      @(negedge clk);
    end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL hold handshake got=%h want=0", rsp_valid); end
    total++; if (op_count !== 16'd2) begin bad++; $display("FAIL hold op_count got=%h want=0002", op_count); end
    total++; if (rsp_tag !== 4'h5) begin bad++; $display("FAIL hold rsp_tag got=%h want=5", rsp_tag); end
    @(negedge clk);
    total++; if (alu_opcode !== 3'b010 || rsp_valid !== 1'b0) begin bad++; $display("FAIL hold no_accept got=%b/%h want=010/0", alu_opcode, rsp_valid); end
  endtask

  task automatic test_div_err();
    int lat;
    rsp_ready = 1'b1;
    issue(3'd3, 8'h20, 8'h00, 4'h9, lat);
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL div0 rsp_err got=%h want=1", rsp_err); end
    total++; if (rsp_data !== 16'hFFFF) begin bad++; $display("FAIL div0 rsp_data got=%h want=ffff", rsp_data); end
    total++; if (rsp_tag !== 4'h9) begin bad++; $display("FAIL div0 rsp_tag got=%h want=9", rsp_tag); end
    issue(3'd3, 8'h20, 8'h04, 4'hA, lat);
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL div rsp_err got=%h want=0", rsp_err); end
    total++; if (rsp_data !== 16'h0008) begin bad++; $display("FAIL div rsp_data got=%h want=0008", rsp_data); end
    @(negedge clk);
    total++; if (op_count !== 16'd4) begin bad++; $display("FAIL div op_count got=%h want=0004", op_count); end
  endtask

  task automatic test_reset_mid();
    int seen;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_op = 3'd6; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_tag = 4'h6; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (alu_opcode !== 3'b110 || cmd_ready !== 1'b0) begin bad++; $display("FAIL rmid accept got=%b/%h want=110/0", alu_opcode, cmd_ready); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid rsp_valid got=%h want=0", rsp_valid); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid cmd_ready got=%h want=1", cmd_ready); end
    total++; if (alu_opcode !== 3'b000 || alu_a !== 8'h00) begin bad++; $display("FAIL rmid alu got=%b/%h want=000/00", alu_opcode, alu_a); end
    total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL rmid op_count got=%h want=0000", op_count); end
    seen = 0;
    repeat (8) begin @(negedge clk); if (rsp_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid ghost_rsp got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops  [4] = '{3'd1, 3'd4, 3'd5, 3'd7};
    logic [7:0]  as   [4] = '{8'h10, 8'hF0, 8'hA0, 8'hC3};
    logic [7:0]  bs   [4] = '{8'h20, 8'h3C, 8'h05, 8'h0F};
    logic [15:0] exps [4] = '{16'hFFF0, 16'h0030, 16'h00A5, 16'h0033};
    int acc_cyc [4];
    int cyc, i, r;
    logic acc;
    rsp_ready3 = 1'b1;
    cyc = 0; i = 0; r = 0;
    @(negedge clk);
    cmd_op3 = ops[0]; cmd_a3 = as[0]; cmd_b3 = bs[0]; cmd_tag3 = 4'd1; cmd_valid3 = 1'b1;
    while (r < 4 && cyc < 200) begin
      acc = cmd_valid3 && cmd_ready3;
      if (acc && i < 4) begin
        acc_cyc[i] = cyc + 1;
        if (i > 0) begin
          total++; if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin bad++; $display("FAIL b2b spacing op%0d got=%0d want=6", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
      end
      @(posedge clk); cyc++;
      #1;
      if (acc && i < 4) begin
        i++;
        if (i < 4) begin cmd_op3 = ops[i]; cmd_a3 = as[i]; cmd_b3 = bs[i]; cmd_tag3 = 4'(i + 1); end
        else cmd_valid3 = 1'b0;
      end
      @(negedge clk);
      if (rsp_valid3 && r < i) begin
        total++; if (cyc - acc_cyc[r] !== 4) begin bad++; $display("FAIL b2b latency op%0d got=%0d want=4", r, cyc - acc_cyc[r]); end
        total++; if (rsp_data3 !== exps[r]) begin bad++; $display("FAIL b2b data op%0d got=%h want=%h", r, rsp_data3, exps[r]); end
        total++; if (rsp_tag3 !== 4'(r + 1)) begin bad++; $display("FAIL b2b tag op%0d got=%h want=%h", r, rsp_tag3, 4'(r + 1)); end
        r++;
      end
    end
    cmd_valid3 = 1'b0;
    total++; if (r !== 4) begin bad++; $display("FAIL b2b responses got=%0d want=4", r); end
    @(negedge clk);
    total++; if (op_count3 !== 16'd4) begin bad++; $display("FAIL b2b op_count got=%h want=0004", op_count3); end
  endtask

  task automatic test_wrap();
    int lat;
    rsp_ready = 1'b1;
    @(negedge clk);
    force dut1.op_count = 16'hFFFF;
    #1 release dut1.op_count;
    issue(3'd0, 8'h01, 8'h02, 4'hC, lat);
    total++; if (rsp_data !== 16'h0003) begin bad++; $display("FAIL wrap rsp_data got=%h want=0003", rsp_data); end
    @(negedge clk);
    total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL wrap op_count got=%h want=0000", op_count); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; rsp_ready = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready3 = 1'b0; cmd_valid3 = 1'b0;
    cmd_op3 = '0; cmd_a3 = '0; cmd_b3 = '0; cmd_tag3 = '0;
    test_reset();
    test_add();
    test_resp_hold();
    test_div_err();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
